// File: rtl/vga_vram_arbiter_pkg.sv
// Shared types and defaults for the VGA/CPU video RAM arbiter.
//   VRAM_ADDR_WIDTH / VRAM_DATA_WIDTH : default VRAM geometry
//   CPU_MAX_WAIT_DEFAULT             : default CPU starvation threshold
//   cpu_state_e                      : CPU-side transaction state
package vga_vram_arbiter_pkg;

   localparam int unsigned VRAM_ADDR_WIDTH      = 12;
   localparam int unsigned VRAM_DATA_WIDTH      = 32;
   localparam int unsigned CPU_MAX_WAIT_DEFAULT = 64;

   typedef enum logic [1:0] {
      CPU_IDLE    = 2'd0,
      CPU_RD_ADDR = 2'd1,
      CPU_RD_DATA = 2'd2,
      CPU_ACK     = 2'd3
   } cpu_state_e;

   // State entered on a CPU grant: writes complete immediately, reads walk the pipe.
   function automatic cpu_state_e cpu_grant_state(input logic write);
      return write ? CPU_ACK : CPU_RD_ADDR;
   endfunction

endpackage

// File: rtl/vga_vram_arbiter.sv
// Arbitrates one single-port synchronous VRAM between video scanout (strict
// priority) and a CPU req/ack port served in free cycles.
// Ports:
//   clock, reset                 : single clock, synchronous active-high reset
//   video_req/addr               : one-cycle fetch request
//   video_data/video_data_valid  : fetched word, pulsed 3 edges after request
//   cpu_req/write/addr/wdata/be  : CPU request, held until cpu_ack
//   cpu_rdata/cpu_ack            : completion pulse (with read data on reads)
//   cpu_starved                  : CPU waited CPU_MAX_WAIT cycles without grant
//   mem_addr/we/be/wdata/rdata   : registered VRAM interface, 1-cycle read latency
module vga_vram_arbiter
   import vga_vram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = VRAM_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH   = VRAM_DATA_WIDTH,
   parameter int unsigned CPU_MAX_WAIT = CPU_MAX_WAIT_DEFAULT
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    video_req,
   input  logic [ADDR_WIDTH-1:0]   video_addr,
   output logic [DATA_WIDTH-1:0]   video_data,
   output logic                    video_data_valid,
   input  logic                    cpu_req,
   input  logic                    cpu_write,
   input  logic [ADDR_WIDTH-1:0]   cpu_addr,
   input  logic [DATA_WIDTH-1:0]   cpu_wdata,
   input  logic [DATA_WIDTH/8-1:0] cpu_be,
   output logic [DATA_WIDTH-1:0]   cpu_rdata,
   output logic                    cpu_ack,
   output logic                    cpu_starved,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic                    mem_we,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
   localparam int unsigned CNT_WIDTH = $clog2(CPU_MAX_WAIT + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(CPU_MAX_WAIT);

   cpu_state_e            state_q, state_d;
   logic                  grant_video_c;
   logic                  grant_cpu_c;
   logic [CNT_WIDTH-1:0]  wait_q, wait_d;

   logic [1:0]            vpipe_q;
   logic [DATA_WIDTH-1:0] video_data_q;
   logic                  video_valid_q;
   logic [DATA_WIDTH-1:0] cpu_rdata_q;
   logic                  cpu_ack_q;
   logic                  cpu_starved_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic                  mem_we_q;
   logic [BE_WIDTH-1:0]   mem_be_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;

   // CPU state register
   always_ff @(posedge clock) begin
      if (reset) state_q <= CPU_IDLE;
      else       state_q <= state_d;
   end

   // Grant decision, CPU next state and wait counter
   always_comb begin
      state_d       = state_q;
      grant_video_c = video_req;
      grant_cpu_c   = 1'b0;
      wait_d        = wait_q;
      unique case (state_q)
         CPU_IDLE: begin
            if (!video_req && cpu_req) begin
               grant_cpu_c = 1'b1;
               state_d     = cpu_grant_state(cpu_write);
            end
         end
         CPU_RD_ADDR: state_d = CPU_RD_DATA;
         CPU_RD_DATA: state_d = CPU_ACK;
         CPU_ACK:     state_d = CPU_IDLE;
         default:     state_d = CPU_IDLE;
      endcase
      if (grant_cpu_c) begin
         wait_d = '0;
      end else if (state_q == CPU_IDLE && cpu_req && wait_q != CNT_MAX) begin
         wait_d = wait_q + CNT_WIDTH'(1);
      end
   end

   // Registered datapath: VRAM command, video valid pipe, CPU response
   always_ff @(posedge clock) begin
      if (reset) begin
         wait_q        <= '0;
         vpipe_q       <= '0;
         video_data_q  <= '0;
         video_valid_q <= 1'b0;
         cpu_rdata_q   <= '0;
         cpu_ack_q     <= 1'b0;
         cpu_starved_q <= 1'b0;
         mem_addr_q    <= '0;
         mem_we_q      <= 1'b0;
         mem_be_q      <= '0;
         mem_wdata_q   <= '0;
      end else begin
         wait_q        <= wait_d;
         cpu_starved_q <= (wait_d == CNT_MAX);
         if (grant_video_c)    mem_addr_q <= video_addr;
         else if (grant_cpu_c) mem_addr_q <= cpu_addr;
         mem_we_q <= grant_cpu_c && cpu_write;
         if (grant_cpu_c && cpu_write) begin
            mem_be_q    <= cpu_be;
            mem_wdata_q <= cpu_wdata;
         end
         // mem_rdata for a read granted two edges ago is present now
         vpipe_q       <= {vpipe_q[0], grant_video_c};
         video_valid_q <= vpipe_q[1];
         if (vpipe_q[1]) video_data_q <= mem_rdata;
         if (state_q == CPU_RD_DATA) cpu_rdata_q <= mem_rdata;
         cpu_ack_q <= (state_d == CPU_ACK);
      end
   end

   assign video_data       = video_data_q;
   assign video_data_valid = video_valid_q;
   assign cpu_rdata        = cpu_rdata_q;
   assign cpu_ack          = cpu_ack_q;
   assign cpu_starved      = cpu_starved_q;
   assign mem_addr         = mem_addr_q;
   assign mem_we           = mem_we_q;
   assign mem_be           = mem_be_q;
   assign mem_wdata        = mem_wdata_q;

endmodule
